// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and datapath types.
// Provides word/register-index widths and the hardwired zero register index.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regidx_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB register, the decode read ports and the regfile.
// master: pipeline side (drives WB inputs and read indices); slave: regfile side.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic              RegWrite_W;
    logic              MemToReg_W;
    logic [DATA_W-1:0] MemData_W;
    logic [DATA_W-1:0] ALUout_W;
    logic [ADDR_W-1:0] WriteReg_W;
    logic [ADDR_W-1:0] ReadReg1_D;
    logic [ADDR_W-1:0] ReadReg2_D;
    logic [DATA_W-1:0] ReadData1_D;
    logic [DATA_W-1:0] ReadData2_D;
    logic [DATA_W-1:0] Result_W;

    modport master (
        output RegWrite_W, MemToReg_W, MemData_W, ALUout_W, WriteReg_W,
        output ReadReg1_D, ReadReg2_D,
        input  ReadData1_D, ReadData2_D, Result_W
    );

    modport slave (
        input  RegWrite_W, MemToReg_W, MemData_W, ALUout_W, WriteReg_W,
        input  ReadReg1_D, ReadReg2_D,
        output ReadData1_D, ReadData2_D, Result_W
    );

endinterface

// File: rtl/wb_result_mux.sv
// Writeback result select: load data or ALU result.
// Ports: sel (1 = mem_data), mem_data, alu_out, result.
module wb_result_mux #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] mem_data,
    input  logic [W-1:0] alu_out,
    output logic [W-1:0] result
);

    assign result = sel ? mem_data : alu_out;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 2R1W architectural register file with WB->ID bypass.
// Ports: clk, rst (async, active-high), bus (slave side of wb_regfile_if).
module wb_regfile #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    import mips_pkg::*;

    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] result;
    logic              commit;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    wb_result_mux #(
        .W (DATA_W)
    ) u_result_mux (
        .sel      (bus.MemToReg_W),
        .mem_data (bus.MemData_W),
        .alu_out  (bus.ALUout_W),
        .result   (result)
    );

    assign commit = bus.RegWrite_W && (bus.WriteReg_W != ZERO_IDX);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.WriteReg_W] <= result;
        end
    end

    // Read ports: zero index and reset force 0; a pending commit to the
    // same index is bypassed so ID sees the value in the WB cycle.
    always_comb begin
        rd1 = '0;
        if (!rst && bus.ReadReg1_D != ZERO_IDX) begin
            if (commit && bus.WriteReg_W == bus.ReadReg1_D) begin
                rd1 = result;
            end else begin
                rd1 = regs[bus.ReadReg1_D];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (!rst && bus.ReadReg2_D != ZERO_IDX) begin
            if (commit && bus.WriteReg_W == bus.ReadReg2_D) begin
                rd2 = result;
            end else begin
                rd2 = regs[bus.ReadReg2_D];
            end
        end
    end

    assign bus.ReadData1_D = rd1;
    assign bus.ReadData2_D = rd2;
    assign bus.Result_W    = result;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset corner
// sequences and randomized traffic against an array-based reference model.
module tb_wb_regfile;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] er;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [31:0] mdl [32];
    vec_t        vecs [11];

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_regfile #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic        rw,
        input logic        m2r,
        input logic [31:0] mem,
        input logic [31:0] alu,
        input logic [4:0]  wr,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [31:0] e1,
        input logic [31:0] e2,
        input logic [31:0] er
    );
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.mem = mem; v.alu = alu;
        v.wr = wr; v.r1 = r1; v.r2 = r2;
        v.e1 = e1; v.e2 = e2; v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] wr, input logic [4:0] r1,
                         input logic [4:0] r2);
        bus.RegWrite_W = rw;
        bus.MemToReg_W = m2r;
        bus.MemData_W  = mem;
        bus.ALUout_W   = alu;
        bus.WriteReg_W = wr;
        bus.ReadReg1_D = r1;
        bus.ReadReg2_D = r2;
    endtask

    // Reference model: what the architecture says a read returns this cycle.
    function automatic logic [31:0] ref_res();
        return bus.MemToReg_W ? bus.MemData_W : bus.ALUout_W;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (rst || idx == 5'd0) return 32'h0;
        if (bus.RegWrite_W && bus.WriteReg_W == idx) return ref_res();
        return mdl[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // Called just after the rising edge with the inputs still applied.
    task automatic model_edge(input logic [31:0] res);
        if (!rst && bus.RegWrite_W && bus.WriteReg_W != 5'd0)
            mdl[bus.WriteReg_W] = res;
    endtask

    // Inputs already applied after a rising edge; check at the falling edge,
    // then commit at the next rising edge.
    task automatic cycle_model(input string tag);
        logic [31:0] res;
        @(negedge clk);
        res = ref_res();
        check({tag, "_rd1"}, bus.ReadData1_D, ref_read(bus.ReadReg1_D));
        check({tag, "_rd2"}, bus.ReadData2_D, ref_read(bus.ReadReg2_D));
        check({tag, "_res"}, bus.Result_W, res);
        @(posedge clk);
        model_edge(res);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_clear();

        vecs[0]  = mk(1'b1, 1'b0, 32'h0, 32'h12345678, 5'd7, 5'd7, 5'd7,
                      32'h12345678, 32'h12345678, 32'h12345678);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7,
                      32'h12345678, 32'h12345678, 32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 32'hCAFEF00D, 32'h1, 5'd9, 5'd9, 5'd3,
                      32'hCAFEF00D, 32'h0, 32'hCAFEF00D);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0,
                      32'h0, 32'h0, 32'hFFFFFFFF);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9,
                      32'h0, 32'hCAFEF00D, 32'h0);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0, 32'h11, 5'd4, 5'd4, 5'd7,
                      32'h11, 32'h12345678, 32'h11);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0, 32'h22, 5'd4, 5'd4, 5'd4,
                      32'h11, 32'h11, 32'h22);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0, 32'h22, 5'd4, 5'd4, 5'd0,
                      32'h11, 32'h0, 32'h22);
        vecs[8]  = mk(1'b1, 1'b1, 32'hAAAA0001, 32'h5, 5'd31, 5'd31, 5'd31,
                      32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001);
        vecs[9]  = mk(1'b1, 1'b0, 32'h0, 32'h2, 5'd31, 5'd31, 5'd4,
                      32'h2, 32'h11, 32'h2);
        vecs[10] = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd9,
                      32'h2, 32'hCAFEF00D, 32'h0);

        // Reset state
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h0BAD0BAD, 32'h0, 5'd5, 5'd5, 5'd31);
        @(negedge clk);
        check("reset_rd1", bus.ReadData1_D, 32'h0);
        check("reset_rd2", bus.ReadData2_D, 32'h0);
        check("reset_res", bus.Result_W, 32'h0BAD0BAD);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            logic [31:0] res;
            drive(vecs[i].rw, vecs[i].m2r, vecs[i].mem, vecs[i].alu,
                  vecs[i].wr, vecs[i].r1, vecs[i].r2);
            @(negedge clk);
            res = ref_res();
            check($sformatf("vec%0d_rd1", i), bus.ReadData1_D, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), bus.ReadData2_D, vecs[i].e2);
            check($sformatf("vec%0d_res", i), bus.Result_W, vecs[i].er);
            @(posedge clk);
            model_edge(res);
            #1;
        end

        // Reset after writing r5: everything reads 0 afterwards
        drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd31);
        cycle_model("wr_r5");
        drive(1'b0, 1'b1, 32'h77, 32'h0, 5'd5, 5'd5, 5'd31);
        #1 rst = 1'b1;
        @(negedge clk);
        check("inrst_rd1", bus.ReadData1_D, 32'h0);
        check("inrst_rd2", bus.ReadData2_D, 32'h0);
        check("inrst_res", bus.Result_W, 32'h77);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_r5", bus.ReadData1_D, 32'h0);
        check("postrst_r31", bus.ReadData2_D, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd5);
        cycle_model("postrst_swap");

        // Async reset during a pending commit of 0x55 to r12
        drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd12, 5'd12, 5'd0);
        @(negedge clk);
        check("pend_bypass", bus.ReadData1_D, 32'h55);
        #2 rst = 1'b1;
        #1;
        check("midrst_rd1", bus.ReadData1_D, 32'h0);
        check("midrst_res", bus.Result_W, 32'h55);
        model_clear();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd12);
        rst = 1'b0;
        @(negedge clk);
        check("abort_r12_p1", bus.ReadData1_D, 32'h0);
        check("abort_r12_p2", bus.ReadData2_D, 32'h0);
        @(posedge clk);
        #1;

        // Randomized traffic; small index range often collides for bypass
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            logic [4:0] r1;
            logic [4:0] r2;
            if ($urandom_range(0, 1) == 0) begin
                wr = 5'($urandom_range(0, 5));
                r1 = 5'($urandom_range(0, 5));
                r2 = 5'($urandom_range(0, 5));
            end else begin
                wr = 5'($urandom);
                r1 = 5'($urandom);
                r2 = 5'($urandom);
            end
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, wr, r1, r2);
            cycle_model("rand");
        end

        // Back-to-back writes to one index: last edge wins
        drive(1'b1, 1'b0, 32'h0, 32'h100, 5'd20, 5'd20, 5'd20);
        cycle_model("b2b_a");
        drive(1'b1, 1'b1, 32'h200, 32'h0, 5'd20, 5'd20, 5'd1);
        cycle_model("b2b_b");
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd20, 5'd20, 5'd0);
        @(negedge clk);
        check("b2b_last", bus.ReadData1_D, 32'h200);
        check("b2b_r0", bus.ReadData2_D, 32'h0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file of the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs (`RegWrite_W`, `MemToReg_W`, `MemData_W`, `ALUout_W`, `WriteReg_W`) and selects the writeback result. It commits that result into a 32×32-bit register file and serves the two decode-stage read ports. Same-cycle write-to-read bypass makes a WB-stage write visible to the instruction in ID in the same cycle.

## Interface
Parameters:
- `DATA_W`, 32, register and datapath width
- `ADDR_W`, 5, register index width (2^ADDR_W registers)

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `RegWrite_W`  in  1  commit enable from MEM/WB
- `MemToReg_W`  in  1  1 selects `MemData_W`, 0 selects `ALUout_W`
- `MemData_W`  in  DATA_W  load data from MEM/WB
- `ALUout_W`  in  DATA_W  ALU result from MEM/WB
- `WriteReg_W`  in  ADDR_W  destination register index
- `ReadReg1_D`  in  ADDR_W  rs index from decode
- `ReadReg2_D`  in  ADDR_W  rt index from decode
- `ReadData1_D`  out  DATA_W  rs value
- `ReadData2_D`  out  DATA_W  rt value
- `Result_W`  out  DATA_W  selected writeback value, exported to the EX forwarding mux

## Operation
- `Result_W = MemToReg_W ? MemData_W : ALUout_W`. This is pure combinational logic and is valid regardless of `RegWrite_W`.
- A commit occurs when `RegWrite_W==1 && WriteReg_W!=0`. The register `regs[WriteReg_W]` takes `Result_W` at the rising edge.
- Register 0 is hardwired to zero. Writes to index 0 are discarded, and reads of index 0 return 0 even when bypass conditions match.
- Each read port is combinational (asynchronous read):
  - If `ReadRegN_D==0`, the port returns 0.
  - Otherwise, if a commit is pending this cycle with `WriteReg_W==ReadRegN_D`, the port returns `Result_W` (bypass).
  - Otherwise, the port returns `regs[ReadRegN_D]`.
- Both ports are independent. Both may address the same register, and both may bypass simultaneously.
- With `RegWrite_W==0`, no state changes and bypass is disabled, even if `WriteReg_W` matches a read index.
- Reset clears all registers to 0 asynchronously.
  - A `rst` assertion aborts any commit in that cycle.
  - While `rst` is high, the read ports return 0 for every index (no bypass).
  - `Result_W` still follows its inputs during reset.

## Timing
- Write latency: a value is committed at the rising edge that ends the WB cycle. The same value is visible on a matching read port during that WB cycle through the bypass.
- Read latency: 0 cycles, combinational from `ReadRegN_D`, `regs`, and the WB inputs.
- Reset values:
  - `ReadData1_D` = 0 and `ReadData2_D` = 0.
  - `Result_W` = mux of the current inputs (no storage).
- The first commit can occur at the first rising edge after `rst` deasserts.
- There is no stall or flush input. Bubbles arrive as `RegWrite_W=0` from the upstream pipeline register.
- Back-to-back writes to the same index: the last edge wins. Each cycle's bypass reflects only that cycle's WB inputs.

## Structure
- Shared package `mips_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`
  - `REG_ZERO = 0`
  - typedefs `word_t` (`DATA_W` bits) and `regidx_t` (`ADDR_W` bits)
- Sub-module `wb_result_mux` isolates the MemToReg select. It is reused by the EX forwarding logic.
- The register array and the bypass compare live in `wb_regfile`.

## Test plan
- Reset then read: assert `rst` mid-run after writing r5=0xDEADBEEF, then deassert -> reading r5 and r31 on both ports returns 0.
- Basic commit: cycle 0 drives `RegWrite_W=1`, `MemToReg_W=0`, `ALUout_W=0x12345678`, `WriteReg_W=7`; cycle 1 drives `RegWrite_W=0` and reads r7 -> `0x12345678` on both ports.
- Bypass plus mux select: drive `RegWrite_W=1`, `MemToReg_W=1`, `MemData_W=0xCAFEF00D`, `WriteReg_W=9`, `ReadReg1_D=9`, `ReadReg2_D=3` in the same cycle -> `ReadData1_D=0xCAFEF00D`, `ReadData2_D=old r3`, `Result_W=0xCAFEF00D`.
- Zero register: write 0xFFFFFFFF to r0 with `RegWrite_W=1` while reading r0 on both ports -> 0 in that cycle and in all later cycles.
- Disabled write: preload r4=0x11, then drive `RegWrite_W=0`, `WriteReg_W=4`, `ALUout_W=0x22`, `ReadReg1_D=4` -> returns 0x11 in that cycle and the next.
- Async reset mid-commit: assert `rst` between edges during a pending write of 0x55 to r12 -> r12 reads 0 after reset releases.
